// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Requester-side and memory-side signals of the shared memory port.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          dm_req;
    logic          dm_we;
    logic [1:0]    dm_wbits;
    logic [2:0]    dm_rbits;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;
    logic          if_stall;
    logic          dm_stall;
    logic          mem_req;
    logic          mem_we;
    logic [1:0]    mem_wbits;
    logic [2:0]    mem_rbits;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          err;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_wbits, dm_rbits, dm_addr, dm_wdata,
               mem_rdata, mem_ack,
        output if_rdata, if_ack, dm_rdata, dm_ack, if_stall, dm_stall,
               mem_req, mem_we, mem_wbits, mem_rbits, mem_addr, mem_wdata, err
    );

    // Requesters plus memory, as seen from outside the arbiter
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_wbits, dm_rbits, dm_addr, dm_wdata,
               mem_rdata, mem_ack,
        input  if_rdata, if_ack, dm_rdata, dm_ack, if_stall, dm_stall,
               mem_req, mem_we, mem_wbits, mem_rbits, mem_addr, mem_wdata, err
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between instruction fetch and data access.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int         AW          = 32,
    parameter int         DW          = 32,
    parameter int         STARVE_MAX  = 4,
    parameter int         TIMEOUT     = 64,
    parameter logic [2:0] FETCH_RBITS = 3'b010
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_port_arbiter_if.slave  bus
);
    localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] c_STARVE_MAX = SW'(STARVE_MAX);
    localparam logic [TW-1:0] c_LAST_WAIT  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY_IF = 2'd1,
        S_BUSY_DM = 2'd2
    } state_t;

    state_t        r_state;
    logic [SW-1:0] r_starveCnt;
    logic [TW-1:0] r_waitCnt;
    logic          r_memReq;
    logic          r_memWe;
    logic [1:0]    r_memWbits;
    logic [2:0]    r_memRbits;
    logic [AW-1:0] r_memAddr;
    logic [DW-1:0] r_memWdata;
    logic          r_ifAck;
    logic          r_dmAck;
    logic [DW-1:0] r_ifRdata;
    logic [DW-1:0] r_dmRdata;
    logic          r_err;

    logic w_ifElig;
    logic w_dmElig;
    logic w_grantIf;

    // A request still high during its own ack cycle is stale and must not re-grant
    assign w_ifElig  = bus.if_req & ~r_ifAck;
    assign w_dmElig  = bus.dm_req & ~r_dmAck;
    assign w_grantIf = w_ifElig & (~w_dmElig | (r_starveCnt == c_STARVE_MAX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_starveCnt <= '0;
            r_waitCnt   <= '0;
            r_memReq    <= 1'b0;
            r_memWe     <= 1'b0;
            r_memWbits  <= '0;
            r_memRbits  <= '0;
            r_memAddr   <= '0;
            r_memWdata  <= '0;
            r_ifAck     <= 1'b0;
            r_dmAck     <= 1'b0;
            r_ifRdata   <= '0;
            r_dmRdata   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_ifAck <= 1'b0;
            r_dmAck <= 1'b0;
            r_err   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_grantIf) begin
                        r_state    <= S_BUSY_IF;
                        r_memReq   <= 1'b1;
                        r_waitCnt  <= '0;
                        r_memWe    <= 1'b0;
                        r_memWbits <= '0;
                        r_memRbits <= FETCH_RBITS;
                        r_memAddr  <= bus.if_addr;
                        r_memWdata <= '0;
                    end else if (w_dmElig) begin
                        r_state    <= S_BUSY_DM;
                        r_memReq   <= 1'b1;
                        r_waitCnt  <= '0;
                        r_memWe    <= bus.dm_we;
                        r_memWbits <= bus.dm_wbits;
                        r_memRbits <= bus.dm_rbits;
                        r_memAddr  <= bus.dm_addr;
                        r_memWdata <= bus.dm_wdata;
                    end
                    // Only a DM grant that overtakes a waiting fetch counts as starvation
                    if (w_grantIf || !w_ifElig) begin
                        r_starveCnt <= '0;
                    end else begin
                        r_starveCnt <= r_starveCnt + SW'(1);
                    end
                end
                S_BUSY_IF, S_BUSY_DM: begin
                    if (bus.mem_ack || (r_waitCnt == c_LAST_WAIT)) begin
                        r_state  <= S_IDLE;
                        r_memReq <= 1'b0;
                        r_err    <= ~bus.mem_ack;
                        if (r_state == S_BUSY_IF) begin
                            r_ifAck   <= 1'b1;
                            r_ifRdata <= bus.mem_ack ? bus.mem_rdata : '0;
                        end else begin
                            r_dmAck   <= 1'b1;
                            r_dmRdata <= (bus.mem_ack && !r_memWe) ? bus.mem_rdata : '0;
                        end
                    end else begin
                        r_waitCnt <= r_waitCnt + TW'(1);
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_memReq <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req   = r_memReq;
    assign bus.mem_we    = r_memWe;
    assign bus.mem_wbits = r_memWbits;
    assign bus.mem_rbits = r_memRbits;
    assign bus.mem_addr  = r_memAddr;
    assign bus.mem_wdata = r_memWdata;
    assign bus.if_ack    = r_ifAck;
    assign bus.dm_ack    = r_dmAck;
    assign bus.if_rdata  = r_ifRdata;
    assign bus.dm_rdata  = r_dmRdata;
    assign bus.err       = r_err;
    assign bus.if_stall  = bus.if_req & ~r_ifAck;
    assign bus.dm_stall  = bus.dm_req & ~r_dmAck;
endmodule
`default_nettype wire
